// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt entry controller: irq sync, pending, mask, undefined-instr trap
module exc_ctrl #(
    parameter int              NIRQ     = 4,
    parameter logic [NIRQ-1:0] MASK_RST = {NIRQ{1'b1}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_din,
    input  logic            instr_valid,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic            pc_kernel,
    input  logic            eret,
    output logic            exc_req,
    output logic [2:0]      exc_pcsrc,
    output logic [3:0]      exc_cause,
    output logic [NIRQ-1:0] irq_ack,
    output logic [NIRQ-1:0] pending,
    output logic [NIRQ-1:0] irq_mask,
    output logic            in_isr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAKE = 2'd1,
        ISR  = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [NIRQ-1:0] sync1, sync2, sync3;
    logic [NIRQ-1:0] rise;
    logic            illegal;
    logic [NIRQ-1:0] eligible;
    logic [NIRQ-1:0] win_onehot;
    logic [2:0]      win_idx;
    logic            found;
    logic            exc_req_d;
    logic [2:0]      exc_pcsrc_d;
    logic [3:0]      exc_cause_d;
    logic [NIRQ-1:0] irq_ack_d;

    assign rise   = sync2 & ~sync3;
    assign in_isr = (state == ISR);

    // Synchroniser, edge-detect stage and pending latch; a fresh rise beats the ack clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1    <= '0;
            sync2    <= '0;
            sync3    <= '0;
            pending  <= '0;
            irq_mask <= MASK_RST;
        end else begin
            sync1   <= irq_in;
            sync2   <= sync1;
            sync3   <= sync2;
            pending <= (pending & ~irq_ack) | rise;
            if (mask_we)
                irq_mask <= mask_din;
        end
    end

    always_comb begin
        illegal = 1'b1;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2a, 6'h2b: illegal = 1'b0;
                    default:      illegal = 1'b1;
                endcase
            end
            6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
            6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f, 6'h23, 6'h2b: illegal = 1'b0;
            default: illegal = 1'b1;
        endcase
    end

    // Lowest-index enabled pending channel wins
    always_comb begin
        eligible   = pending & irq_mask;
        win_onehot = '0;
        win_idx    = 3'd0;
        found      = 1'b0;
        for (int i = 0; i < NIRQ; i++) begin
            if (eligible[i] && !found) begin
                found         = 1'b1;
                win_onehot[i] = 1'b1;
                win_idx       = 3'(i);
            end
        end
    end

    always_comb begin
        state_d     = state;
        exc_req_d   = 1'b0;
        exc_pcsrc_d = 3'h0;
        exc_cause_d = 4'h0;
        irq_ack_d   = '0;
        case (state)
            IDLE: begin
                if (instr_valid && !pc_kernel && (illegal || found)) begin
                    state_d   = TAKE;
                    exc_req_d = 1'b1;
                    if (illegal) begin
                        exc_pcsrc_d = 3'h5;
                        exc_cause_d = 4'h1;
                    end else begin
                        exc_pcsrc_d = 3'h4;
                        exc_cause_d = {1'b1, win_idx};
                        irq_ack_d   = win_onehot;
                    end
                end
            end
            TAKE:    state_d = ISR;
            ISR:     if (instr_valid && eret) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Entry outputs are registered so they are high exactly for the TAKE cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            exc_req   <= 1'b0;
            exc_pcsrc <= 3'h0;
            exc_cause <= 4'h0;
            irq_ack   <= '0;
        end else begin
            state     <= state_d;
            exc_req   <= exc_req_d;
            exc_pcsrc <= exc_pcsrc_d;
            exc_cause <= exc_cause_d;
            irq_ack   <= irq_ack_d;
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed self-checking bench for exc_ctrl
module tb_exc_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_din;
    logic       instr_valid;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       pc_kernel;
    logic       eret;
    logic       exc_req;
    logic [2:0] exc_pcsrc;
    logic [3:0] exc_cause;
    logic [3:0] irq_ack;
    logic [3:0] pending;
    logic [3:0] irq_mask;
    logic       in_isr;

    int errors = 0;
    int checks = 0;

    exc_ctrl #(.NIRQ(4), .MASK_RST(4'hF)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we),
        .mask_din(mask_din), .instr_valid(instr_valid), .opcode(opcode),
        .funct(funct), .pc_kernel(pc_kernel), .eret(eret), .exc_req(exc_req),
        .exc_pcsrc(exc_pcsrc), .exc_cause(exc_cause), .irq_ack(irq_ack),
        .pending(pending), .irq_mask(irq_mask), .in_isr(in_isr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_take(input string tag, input logic [2:0] pc, input logic [3:0] cause,
                            input logic [3:0] ack);
        chk({tag, ".req"},   32'(exc_req),   32'h1);
        chk({tag, ".pcsrc"}, 32'(exc_pcsrc), 32'(pc));
        chk({tag, ".cause"}, 32'(exc_cause), 32'(cause));
        chk({tag, ".ack"},   32'(irq_ack),   32'(ack));
    endtask

    initial begin
        reset = 1'b0; irq_in = 4'h0; mask_we = 1'b0; mask_din = 4'h0;
        instr_valid = 1'b0; opcode = 6'h00; funct = 6'h20; pc_kernel = 1'b0; eret = 1'b0;

        // reset values
        #12;
        chk("rst.req",    32'(exc_req),   32'h0);
        chk("rst.cause",  32'(exc_cause), 32'h0);
        chk("rst.pend",   32'(pending),   32'h0);
        chk("rst.mask",   32'(irq_mask),  32'hF);
        chk("rst.in_isr", 32'(in_isr),    32'h0);
        tick(1);
        reset = 1'b1;

        // channel 2 interrupt latency
        irq_in = 4'b0100; instr_valid = 1'b1;
        tick(2);
        chk("a.pend_e2", 32'(pending), 32'h0);
        tick(1);
        chk("a.pend_e3", 32'(pending), 32'h4);
        chk("a.req_e3",  32'(exc_req), 32'h0);
        tick(1);
        chk_take("a.take", 3'h4, 4'hA, 4'b0100);
        tick(1);
        chk("a.isr",     32'(in_isr),  32'h1);
        chk("a.req_off", 32'(exc_req), 32'h0);
        chk("a.pend_clr", 32'(pending), 32'h0);
        eret = 1'b1; irq_in = 4'h0;
        tick(1);
        chk("a.eret", 32'(in_isr), 32'h0);
        eret = 1'b0;

        // undefined instruction decode
        funct = 6'h01;
        tick(1);
        chk_take("b.undef", 3'h5, 4'h1, 4'h0);
        funct = 6'h20;
        tick(1);
        chk("b.isr", 32'(in_isr), 32'h1);
        eret = 1'b1;
        tick(1);
        eret = 1'b0; funct = 6'h2a;
        tick(1);
        chk("b.slt_legal", 32'(exc_req), 32'h0);
        pc_kernel = 1'b1; funct = 6'h01;
        tick(1);
        chk("b.kernel_no_trap", 32'(exc_req), 32'h0);
        pc_kernel = 1'b0; funct = 6'h20; opcode = 6'h10;
        tick(1);
        chk("b.bad_op.cause", 32'(exc_cause), 32'h1);
        opcode = 6'h00;
        tick(1);
        funct = 6'h01;
        tick(1);
        chk("b.isr_ignores_illegal", 32'(exc_req), 32'h0);
        chk("b.isr_hold", 32'(in_isr), 32'h1);
        funct = 6'h20; eret = 1'b1;
        tick(1);
        eret = 1'b0;

        // illegal beats pending, then channels in index order
        instr_valid = 1'b0; irq_in = 4'b1010;
        tick(3);
        chk("c.pend", 32'(pending), 32'hA);
        chk("c.no_req_invalid", 32'(exc_req), 32'h0);
        irq_in = 4'h0; instr_valid = 1'b1; funct = 6'h01;
        tick(1);
        chk_take("c.undef", 3'h5, 4'h1, 4'h0);
        funct = 6'h20;
        tick(1);
        chk("c.pend_kept", 32'(pending), 32'hA);
        eret = 1'b1;
        tick(1);
        eret = 1'b0;
        tick(1);
        chk_take("c.ch1", 3'h4, 4'h9, 4'b0010);
        tick(1);
        chk("c.pend_ch3", 32'(pending), 32'h8);
        eret = 1'b1;
        tick(1);
        eret = 1'b0;
        tick(1);
        chk_take("c.ch3", 3'h4, 4'hB, 4'b1000);
        tick(1);
        chk("c.pend_empty", 32'(pending), 32'h0);
        eret = 1'b1;
        tick(1);
        eret = 1'b0;

        // masked pending is retained and taken once enabled
        mask_we = 1'b1; mask_din = 4'h0;
        tick(1);
        chk("d.mask0", 32'(irq_mask), 32'h0);
        mask_we = 1'b0; irq_in = 4'b0001;
        tick(1);
        irq_in = 4'h0;
        tick(2);
        chk("d.pend", 32'(pending), 32'h1);
        tick(1);
        chk("d.masked_no_req", 32'(exc_req), 32'h0);
        mask_we = 1'b1; mask_din = 4'b0001;
        tick(1);
        chk("d.mask1", 32'(irq_mask), 32'h1);
        chk("d.no_req_yet", 32'(exc_req), 32'h0);
        mask_we = 1'b0;
        tick(1);
        chk_take("d.ch0", 3'h4, 4'h8, 4'b0001);
        tick(1);
        eret = 1'b1;
        tick(1);
        eret = 1'b0;

        // rise coinciding with ack, then async reset in ISR
        mask_we = 1'b1; mask_din = 4'b0111; instr_valid = 1'b0;
        tick(1);
        mask_we = 1'b0; irq_in = 4'b0100;
        tick(1);
        irq_in = 4'h0;
        tick(2);
        chk("e.pend", 32'(pending), 32'h4);
        tick(3);
        irq_in = 4'b0100;
        tick(1);
        instr_valid = 1'b1;
        tick(1);
        chk_take("e.ch2", 3'h4, 4'hA, 4'b0100);
        tick(1);
        chk("e.rise_wins", 32'(pending), 32'h4);
        chk("e.isr", 32'(in_isr), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("e.rst.in_isr", 32'(in_isr),   32'h0);
        chk("e.rst.req",    32'(exc_req),  32'h0);
        chk("e.rst.pend",   32'(pending),  32'h0);
        chk("e.rst.mask",   32'(irq_mask), 32'hF);
        chk("e.rst.pcsrc",  32'(exc_pcsrc), 32'h0);

        // line high across reset release registers as a rise
        irq_in = 4'b0001; instr_valid = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(2);
        chk("f.pend_e2", 32'(pending), 32'h0);
        tick(1);
        chk("f.pend_e3", 32'(pending), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
